// File: rtl/pilha_param.sv
// pilha_param: parametrised LIFO with registered top, level count, full/empty and sticky error flags
module pilha_param #(
  parameter int LARGURA      = 11,
  parameter int PROFUNDIDADE = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LARGURA-1:0]    dado,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  limpa_erro,
  output logic [LARGURA-1:0]    topo,
  output logic [PROFUNDIDADE:0] nivel,
  output logic                  vazia,
  output logic                  cheia,
  output logic                  estouro,
  output logic                  subfluxo
);
  localparam int N = 2 ** PROFUNDIDADE;
  logic [LARGURA-1:0]    mem [0:N-2];
  logic [PROFUNDIDADE:0] nm1, nm2;
  logic                  do_push, do_pop, do_rep, err_o, err_u;
  logic [LARGURA-1:0]    abaixo;
  always_comb begin
    vazia   = nivel == '0;
    cheia   = nivel == (PROFUNDIDADE+1)'(N);
    nm1     = nivel - 1'b1;
    nm2     = nivel - 2'd2;
    do_push = push & (pop ? vazia : ~cheia);
    do_rep  = push & pop & ~vazia;
    do_pop  = pop & ~push & ~vazia;
    err_o   = push & ~pop & cheia;
    err_u   = pop & ~push & vazia;
    abaixo  = nivel >= (PROFUNDIDADE+1)'(2) ? mem[nm2[PROFUNDIDADE-1:0]] : '0;
  end
  // the old top spills into the array only when something was already on the stack
  always_ff @(posedge clk)
    if (!reset && do_push && !vazia) mem[nm1[PROFUNDIDADE-1:0]] <= topo;
  always_ff @(posedge clk) begin
    if (reset) begin
      topo     <= '0;
      nivel    <= '0;
      estouro  <= 1'b0;
      subfluxo <= 1'b0;
    end else begin
      topo     <= (do_push | do_rep) ? dado : do_pop ? abaixo : topo;
      nivel    <= do_push ? nivel + 1'b1 : do_pop ? nivel - 1'b1 : nivel;
      estouro  <= err_o | (estouro & ~limpa_erro);
      subfluxo <= err_u | (subfluxo & ~limpa_erro);
    end
  end
endmodule

// File: tb/tb_pilha_param.sv
// tb_pilha_param: directed vector table, reset corner cases and a queue-model random run
module tb_pilha_param;
  localparam int W = 11;
  localparam int P = 3;
  localparam int N = 2 ** P;
  logic clk = 0, reset = 0, push = 0, pop = 0, limpa_erro = 0;
  logic [W-1:0] dado = '0, topo;
  logic [P:0] nivel;
  logic vazia, cheia, estouro, subfluxo;
  int errors = 0, checks = 0;
  typedef struct {
    logic pu, po, le;
    logic [W-1:0] d, t;
    int n;
    logic eo, su;
  } vec_t;
  vec_t tbl[$];
  logic [W-1:0] q[$];
  logic m_eo, m_su;

  pilha_param #(.LARGURA(W), .PROFUNDIDADE(P)) dut (
    .clk(clk), .reset(reset), .dado(dado), .push(push), .pop(pop),
    .limpa_erro(limpa_erro), .topo(topo), .nivel(nivel), .vazia(vazia),
    .cheia(cheia), .estouro(estouro), .subfluxo(subfluxo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic pu, input logic po, input logic le, input logic [W-1:0] d);
    reset = r; push = pu; pop = po; limpa_erro = le; dado = d;
    @(posedge clk);
    #1;
    reset = 0; push = 0; pop = 0; limpa_erro = 0;
  endtask

  task automatic chk_all(input string nm, input logic [W-1:0] t, input int n, input logic eo, input logic su);
    chk({nm, ".topo"}, 32'(topo), 32'(t));
    chk({nm, ".nivel"}, 32'(nivel), 32'(n));
    chk({nm, ".vazia"}, 32'(vazia), 32'(n == 0));
    chk({nm, ".cheia"}, 32'(cheia), 32'(n == N));
    chk({nm, ".estouro"}, 32'(estouro), 32'(eo));
    chk({nm, ".subfluxo"}, 32'(subfluxo), 32'(su));
  endtask

  function automatic vec_t mk(logic pu, logic po, logic le, logic [W-1:0] d, logic [W-1:0] t, int n, logic eo, logic su);
    vec_t v;
    v.pu = pu; v.po = po; v.le = le; v.d = d; v.t = t; v.n = n; v.eo = eo; v.su = su;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(1, 0, 0, 11'h0A1, 11'h0A1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11'h0B2, 11'h0B2, 2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11'h0C3, 11'h0C3, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h0B2, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h0A1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 11'h000, 11'h000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 11'h000, 11'h000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11'h00F, 11'h00F, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11'h011, 11'h011, 2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 11'h022, 11'h022, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h00F, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 11'h033, 11'h033, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h000, 11'h000, 0, 0, 0));
    for (int i = 1; i <= N; i++) tbl.push_back(mk(1, 0, 0, W'(i), W'(i), i, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11'h009, 11'h008, N, 1, 0));
    tbl.push_back(mk(1, 1, 0, 11'h0AA, 11'h0AA, N, 1, 0));
    for (int i = N - 1; i >= 0; i--) tbl.push_back(mk(0, 1, 0, 11'h000, W'(i), i, 1, 0));
    tbl.push_back(mk(0, 1, 1, 11'h000, 11'h000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 11'h000, 11'h000, 0, 0, 0));

    step(1, 1, 0, 0, 11'h7FF);
    chk_all("reset", 11'h000, 0, 0, 0);
    foreach (tbl[i]) begin
      step(0, tbl[i].pu, tbl[i].po, tbl[i].le, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].t, tbl[i].n, tbl[i].eo, tbl[i].su);
    end

    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, W'(11'h100 + i));
    chk_all("fill5", 11'h104, 5, 0, 0);
    step(1, 1, 0, 0, 11'h1FF);
    chk_all("midreset", 11'h000, 0, 0, 0);
    step(0, 1, 0, 0, 11'h055);
    chk_all("post_reset_push", 11'h055, 1, 0, 0);
    step(0, 0, 1, 0, 11'h000);
    chk_all("no_stale_pop", 11'h000, 0, 0, 0);
    step(0, 0, 1, 0, 11'h000);
    chk_all("no_stale_under", 11'h000, 0, 0, 1);

    step(1, 0, 0, 0, 11'h000);
    q.delete();
    m_eo = 0; m_su = 0;
    for (int c = 0; c < 1500; c++) begin
      logic pu, po, le, eo_ev, su_ev;
      logic [W-1:0] d;
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      le = $urandom_range(0, 7) == 0;
      d = W'($urandom);
      eo_ev = 0; su_ev = 0;
      if (pu && po) begin
        if (q.size() == 0) q.push_back(d);
        else q[q.size() - 1] = d;
      end else if (pu) begin
        if (q.size() == N) eo_ev = 1;
        else q.push_back(d);
      end else if (po) begin
        if (q.size() == 0) su_ev = 1;
        else void'(q.pop_back());
      end
      m_eo = eo_ev | (m_eo & ~le);
      m_su = su_ev | (m_su & ~le);
      step(0, pu, po, le, d);
      chk_all($sformatf("rnd%0d", c), q.size() ? q[q.size() - 1] : '0, q.size(), m_eo, m_su);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pilha_param.md
# pilha_param

Parametrised LIFO stack, successor to the processor's fixed return-address stack. It holds up to 2**PROFUNDIDADE words of LARGURA bits, with the top entry in a register so it is readable with zero latency. Adds a level counter, full/empty flags, atomic replace (push+pop), and sticky overflow/underflow error flags with explicit clear. It sits in the control path: the call/return logic pushes return addresses and the branch logic reads `topo`.

## Interface
- LARGURA, 11, data word width in bits (≥1)
- PROFUNDIDADE, 7, log2 of capacity; capacity N = 2**PROFUNDIDADE entries (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- dado  in  LARGURA  word to push
- push  in  1  push request
- pop  in  1  pop request
- limpa_erro  in  1  clears sticky error flags
- topo  out  LARGURA  current top entry (registered); 0 when empty
- nivel  out  PROFUNDIDADE+1  number of valid entries, 0..N
- vazia  out  1  nivel == 0
- cheia  out  1  nivel == N
- estouro  out  1  sticky: push attempted while full
- subfluxo  out  1  sticky: pop attempted while empty

## Operation
- Storage: `topo` register holds the top entry; array `mem[0..N-2]` holds entries below it, `mem[nivel-2]` being the second entry. Array uses combinational read, registered write; array contents are not reset.
- Reset has priority over all inputs: nivel=0, topo=0, estouro=0, subfluxo=0. vazia=1, cheia=0 follow.
- Per cycle, by {push, pop}:
  - 00: hold.
  - 10, not full: if nivel>0, mem[nivel-1] <= topo; topo <= dado; nivel+1.
  - 10, full: no state change except estouro <= 1; topo, nivel, mem unchanged.
  - 01, not empty: topo <= (nivel≥2) ? mem[nivel-2] : 0; nivel-1.
  - 01, empty: no change except subfluxo <= 1.
  - 11, not empty (incl. full): replace — topo <= dado; nivel and mem unchanged; no error.
  - 11, empty: behaves as a push — topo <= dado, nivel=1; no error.
- limpa_erro: estouro <= 0, subfluxo <= 0, unless a new error occurs in the same cycle, in which case that flag is set (set wins); the other flag clears.
- vazia, cheia: combinational decodes of the nivel register only (glitch-free, no input path).
- nivel arithmetic is PROFUNDIDADE+1 bits wide, so N is representable without wrap; nivel never leaves 0..N.

## Timing
- Zero-latency read: topo is valid in the same cycle for the current state; a push/pop/replace issued in cycle t is visible on topo/nivel/flags after edge t+1.
- Back-to-back operations every cycle are supported, with no bubbles; a pop right after a push returns the pre-push top.
- Reset mid-operation discards all entries at that edge; a push/pop in the reset cycle is ignored.
- No output depends combinationally on push, pop, dado or limpa_erro.

## Test plan
- Reset with push=1: after the edge, nivel=0, vazia=1, cheia=0, topo=0, estouro=subfluxo=0.
- Push 0x0A1, 0x0B2, 0x0C3 -> topo follows A1, B2, C3 and nivel goes 1, 2, 3. Then pop ×3 -> topo=B2, A1, 0; nivel goes 2, 1, 0; vazia=1.
- PROFUNDIDADE=3: push 8 words 1..8 -> cheia=1, nivel=8, topo=8. Then push 9 -> estouro=1, topo=8, nivel=8. Then pop ×8 -> topo=7..1 then 0.
- Empty stack, pop -> subfluxo=1, nivel=0. Then limpa_erro with pop -> subfluxo stays 1. Then limpa_erro alone -> subfluxo=0.
- nivel=2 (topo=0x011), push+pop with dado=0x022 -> topo=0x022, nivel=2. Then pop -> topo is the original bottom entry. On an empty stack, push+pop with dado=0x033 -> nivel=1, topo=0x033.
- nivel=5 with reset asserted together with push -> nivel=0, topo=0. Then push 0x055 -> nivel=1, topo=0x055, with no stale data returned on a following pop.
